// File: rtl/ram_arbiter.sv
// Frame sequencer/arbiter for the shared SRAM: 16-cycle frame, Pi slot 0-1, CPU slot 12-15.
// All outputs registered; one Pi request held in a valid/ready register, pi_ready low while held.
module ram_arbiter #(
  parameter logic [15:0] IO_BASE = 16'hE800,
  parameter logic [15:0] IO_MASK = 16'hF800
) (
  input  logic        clk16,
  input  logic        reset_n,
  input  logic        pi_valid,
  output logic        pi_ready,
  input  logic        pi_rw,
  input  logic [16:0] pi_addr,
  input  logic [7:0]  pi_wdata,
  output logic [7:0]  pi_rdata,
  output logic        pi_done,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_en,
  output logic        io_sel,
  input  logic [7:0]  io_rdata,
  output logic [16:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [3:0]  slot
);

  logic [3:0]  slot_q, slot_d;
  logic        pend_q, pend_d;
  logic        pend_rw_q, pend_rw_d;
  logic [16:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_wdata_q, pend_wdata_d;
  logic        act_q, act_d;

  logic [7:0]  pi_rdata_q, pi_rdata_d;
  logic        pi_done_q, pi_done_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_en_q, cpu_en_d;
  logic        io_sel_q, io_sel_d;
  logic [16:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_oe_n_q, ram_oe_n_d;
  logic        ram_we_n_q, ram_we_n_d;

  logic accept;
  logic pi_finish;
  logic io_hit;
  logic pi_nxt;
  logic cpu_nxt;

  assign accept    = pi_valid && !pend_q;
  assign pi_finish = (slot_q == 4'd1) && act_q;
  assign io_hit    = ((cpu_addr & IO_MASK) == IO_BASE);

  // State register
  always_ff @(posedge clk16 or negedge reset_n) begin
    if (!reset_n) begin
      slot_q       <= 4'd0;
      pend_q       <= 1'b0;
      pend_rw_q    <= 1'b0;
      pend_addr_q  <= 17'd0;
      pend_wdata_q <= 8'd0;
      act_q        <= 1'b0;
      pi_rdata_q   <= 8'd0;
      pi_done_q    <= 1'b0;
      cpu_rdata_q  <= 8'd0;
      cpu_en_q     <= 1'b0;
      io_sel_q     <= 1'b0;
      ram_addr_q   <= 17'd0;
      ram_wdata_q  <= 8'd0;
      ram_oe_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
    end else begin
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      pend_rw_q    <= pend_rw_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      act_q        <= act_d;
      pi_rdata_q   <= pi_rdata_d;
      pi_done_q    <= pi_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_en_q     <= cpu_en_d;
      io_sel_q     <= io_sel_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_we_n_q   <= ram_we_n_d;
    end
  end

  // Next-state: frame counter, holding register and launch
  always_comb begin
    slot_d       = slot_q + 4'd1;
    pend_d       = pend_q;
    pend_rw_d    = pend_rw_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    act_d        = act_q;
    if (accept) begin
      pend_d       = 1'b1;
      pend_rw_d    = pi_rw;
      pend_addr_d  = pi_addr;
      pend_wdata_d = pi_wdata;
    end
    // Launch samples the old pend_q, so a same-edge accept waits a frame.
    if (slot_q == 4'd15) begin
      act_d = pend_q;
    end
    if (pi_finish) begin
      pend_d = 1'b0;
      act_d  = 1'b0;
    end
  end

  // Outputs are computed for the slot about to begin, then registered
  always_comb begin
    pi_nxt      = act_d && (slot_d <= 4'd1);
    cpu_nxt     = (slot_d >= 4'd12);
    pi_rdata_d  = pi_rdata_q;
    pi_done_d   = pi_finish;
    cpu_rdata_d = cpu_rdata_q;
    cpu_en_d    = (slot_d == 4'd15);
    io_sel_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_oe_n_d  = 1'b1;
    ram_we_n_d  = 1'b1;

    if (pi_finish && pend_rw_q) begin
      pi_rdata_d = ram_rdata;
    end
    if ((slot_q == 4'd14) && cpu_rw) begin
      cpu_rdata_d = io_hit ? io_rdata : ram_rdata;
    end

    if (pi_nxt) begin
      ram_addr_d = pend_addr_q;
      if (pend_rw_q) begin
        ram_oe_n_d = 1'b0;
      end else begin
        ram_wdata_d = pend_wdata_q;
        ram_we_n_d  = (slot_d != 4'd0);
      end
    end else if (cpu_nxt) begin
      ram_addr_d  = {1'b0, cpu_addr};
      ram_wdata_d = cpu_wdata;
      if (io_hit) begin
        io_sel_d = (slot_d >= 4'd13);
      end else if (cpu_rw) begin
        ram_oe_n_d = 1'b0;
      end else begin
        ram_we_n_d = (slot_d != 4'd14);
      end
    end
  end

  assign slot      = slot_q;
  assign pi_ready  = !pend_q;
  assign pi_rdata  = pi_rdata_q;
  assign pi_done   = pi_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_en    = cpu_en_q;
  assign io_sel    = io_sel_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_oe_n  = ram_oe_n_q;
  assign ram_we_n  = ram_we_n_q;

endmodule
